fifo_flags: RTL and testbench

- Parametrised synchronous FIFO, the successor to the basic full/empty FIFO.
- Adds an occupancy count, almost-full and almost-empty thresholds, and well-defined simultaneous read/write at the boundaries.
- Optionally adds sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in one clock domain, e.g. UART RX/TX buffering and stream decoupling.

---
 rtl/fifo_flags.sv | 102 ++++++++++
 tb/tb_fifo_flags.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// rtl/fifo_flags.sv - synchronous FIFO with occupancy count, threshold flags and optional sticky errors
// Optional feature macro: FIFO_ERR_FLAGS_EN (sticky overflow/underflow with err_clr).
module fifo_flags #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  input  logic         err_clr,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = 2**W;
  localparam logic [W:0] FULL_CNT = (W+1)'(DEPTH);
  localparam logic [W:0] AF_CNT   = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_CNT   = (W+1)'(AE_LEVEL);

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic [W:0]   count_next;
  logic         wr_ok;
  logic         rd_ok;

  // A write into a full FIFO is legal only when the head is popped in the same cycle.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  always_comb begin
    count_next = count;
    if (wr_ok & ~rd_ok)
      count_next = count + 1'b1;
    else if (~wr_ok & rd_ok)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[w_ptr] <= w_data;
  end

  // Flags are registered from count_next so they move in lockstep with count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok)
        w_ptr <= w_ptr + 1'b1;
      if (rd_ok)
        r_ptr <= r_ptr + 1'b1;
      count        <= count_next;
      full         <= (count_next == FULL_CNT);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_CNT);
      almost_empty <= (count_next <= AE_CNT);
    end
  end

  assign r_data = empty ? '0 : mem[r_ptr];

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full & ~rd)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (rd & empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb/tb_fifo_flags.sv - directed self-checking bench for fifo_flags
module tb_fifo_flags;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       err_clr;
  logic       overflow;
  logic       underflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q[$];

  fifo_flags #(.B(8), .W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd), .r_data(r_data),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " empty"}, 32'(empty), 1);
    check({tag, " almost_empty"}, 32'(almost_empty), 1);
    check({tag, " full"}, 32'(full), 0);
    check({tag, " almost_full"}, 32'(almost_full), 0);
    check({tag, " r_data"}, 32'(r_data), 0);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00; err_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Test 1: reset then idle
    tick(); tick(); tick();
    check_idle("t1");
    check("t1 overflow", 32'(overflow), 0);
    check("t1 underflow", 32'(underflow), 0);

    // Test 2: fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
      check($sformatf("t2 count w%0d", i), 32'(count), 32'(i));
      check($sformatf("t2 almost_empty w%0d", i), 32'(almost_empty), (i <= 2) ? 1 : 0);
      check($sformatf("t2 almost_full w%0d", i), 32'(almost_full), (i >= 14) ? 1 : 0);
      check($sformatf("t2 full w%0d", i), 32'(full), (i == 16) ? 1 : 0);
      check($sformatf("t2 r_data w%0d", i), 32'(r_data), 32'h01);
    end
    wr = 1'b0;

    // Test 3: write when full, no read
    wr = 1'b1; w_data = 8'hAA;
    tick();
    wr = 1'b0;
    check("t3 count", 32'(count), 16);
    check("t3 full", 32'(full), 1);
    check("t3 r_data", 32'(r_data), 32'h01);
`ifdef FIFO_ERR_FLAGS_EN
    check("t3 overflow set", 32'(overflow), 1);
    tick();
    check("t3 overflow sticky", 32'(overflow), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3 overflow cleared", 32'(overflow), 0);
`else
    check("t3 overflow tied", 32'(overflow), 0);
`endif

    // Test 4: simultaneous read/write when full, then drain
    wr = 1'b1; rd = 1'b1; w_data = 8'hBB;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("t4 r_data", 32'(r_data), 32'h02);
    check("t4 count", 32'(count), 16);
    check("t4 full", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4 drain %0d", i), 32'(r_data), (i < 15) ? 32'(i + 2) : 32'hBB);
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    check("t4 empty", 32'(empty), 1);
    check("t4 count end", 32'(count), 0);
    check("t4 r_data end", 32'(r_data), 0);

    // Test 5: simultaneous read/write when empty
    wr = 1'b1; rd = 1'b1; w_data = 8'h5C;
    #1;
    check("t5 r_data same cycle", 32'(r_data), 0);
    tick();
    wr = 1'b0; rd = 1'b0;
    check("t5 count", 32'(count), 1);
    check("t5 empty", 32'(empty), 0);
    check("t5 r_data", 32'(r_data), 32'h5C);
`ifdef FIFO_ERR_FLAGS_EN
    check("t5 underflow", 32'(underflow), 1);
`else
    check("t5 underflow", 32'(underflow), 0);
`endif
    err_clr = 1'b1; rd = 1'b1;
    tick();
    err_clr = 1'b0; rd = 1'b0;
    check("t5 popped empty", 32'(empty), 1);

    // Test 6: reset mid-operation, then wrap-around traffic against a queue model
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; w_data = 8'(8'h30 + i);
      tick();
    end
    check("t6 count before reset", 32'(count), 10);
    #2;
    reset = 1'b1;
    #1;
    check_idle("t6 async");
    tick();
    wr = 1'b0;
    check_idle("t6 in reset");
    reset = 1'b0;
    tick();
    check_idle("t6 after reset");

    q = {};
    for (int i = 0; i < 40; i++) begin
      logic wr_ok, rd_ok;
      wr = (i % 3) != 2;
      rd = (i % 2) == 1;
      w_data = 8'(i * 7 + 3);
      #1;
      check($sformatf("t6 r_data c%0d", i), 32'(r_data), (q.size() > 0) ? 32'(q[0]) : 0);
      wr_ok = wr & ((q.size() != 16) | rd);
      rd_ok = rd & (q.size() != 0);
      tick();
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(8'(i * 7 + 3));
      check($sformatf("t6 count c%0d", i), 32'(count), 32'(q.size()));
      check($sformatf("t6 empty c%0d", i), 32'(empty), (q.size() == 0) ? 1 : 0);
      check($sformatf("t6 full c%0d", i), 32'(full), (q.size() == 16) ? 1 : 0);
    end
    wr = 1'b0; rd = 1'b0;
    while (q.size() > 0) begin
      check("t6 tail drain", 32'(r_data), 32'(q[0]));
      rd = 1'b1;
      tick();
      void'(q.pop_front());
    end
    rd = 1'b0;
    check("t6 final empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
